// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// funct codes, ALU operations and datapath select values.
package mc_ctrl_pkg;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

  localparam logic [1:0] PC_S_PC4    = 2'b00;
  localparam logic [1:0] PC_S_RS     = 2'b01;
  localparam logic [1:0] PC_S_BRANCH = 2'b10;
  localparam logic [1:0] PC_S_JUMP   = 2'b11;

  localparam logic [1:0] WR_RD = 2'b00;
  localparam logic [1:0] WR_RT = 2'b01;
  localparam logic [1:0] WR_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  typedef enum logic [3:0] {
    C_RALU, C_IALU, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/mc_instr_decoder.sv
// Combinational OP/func decode into an instruction class plus the static
// datapath selects that stay constant through EX/MEM/WB.
module mc_instr_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   OP,
  input  logic [5:0]   func,
  output instr_class_t cls,
  output logic [2:0]   alu_op,
  output logic [1:0]   w_r_s,
  output logic         imm_s,
  output logic         rt_imm_s,
  output logic [1:0]   wr_data_s
);

  always_comb begin
    cls       = C_ILLEGAL;
    alu_op    = ALU_AND;
    w_r_s     = WR_RD;
    imm_s     = 1'b0;
    rt_imm_s  = 1'b0;
    wr_data_s = WD_ALU;
    case (OP)
      OP_RTYPE: begin
        cls = C_RALU;
        case (func)
          F_ADD:   alu_op = ALU_ADD;
          F_SUB:   alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_XOR:   alu_op = ALU_XOR;
          F_NOR:   alu_op = ALU_NOR;
          F_SLTU:  alu_op = ALU_SLTU;
          F_SLLV:  alu_op = ALU_SLL;
          F_JR:    cls = C_JR;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        cls = C_IALU; alu_op = ALU_ADD; imm_s = 1'b1; rt_imm_s = 1'b1; w_r_s = WR_RT;
      end
      OP_ANDI: begin
        cls = C_IALU; alu_op = ALU_AND; rt_imm_s = 1'b1; w_r_s = WR_RT;
      end
      OP_XORI: begin
        cls = C_IALU; alu_op = ALU_XOR; rt_imm_s = 1'b1; w_r_s = WR_RT;
      end
      OP_SLTIU: begin
        cls = C_IALU; alu_op = ALU_SLTU; rt_imm_s = 1'b1; w_r_s = WR_RT;
      end
      OP_LW: begin
        cls = C_LW; alu_op = ALU_ADD; imm_s = 1'b1; rt_imm_s = 1'b1;
        w_r_s = WR_RT; wr_data_s = WD_MEM;
      end
      OP_SW: begin
        cls = C_SW; alu_op = ALU_ADD; imm_s = 1'b1; rt_imm_s = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        cls = C_BR; alu_op = ALU_SUB; imm_s = 1'b1;
      end
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM with memory-wait handshake, illegal-instruction
// pulse and retired-instruction counter.
//   state | meaning
//   IF    | fetch, wait for mem_ready, load IR and PC+4
//   ID    | decode; jumps, jr and illegal instructions retire here
//   EX    | ALU operation; branches retire here
//   MEM   | data access, held until mem_ready
//   WB    | register file write
module multi_cycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OP,
  input  logic [5:0]       func,
  input  logic             ZF,
  input  logic             mem_ready,
  output logic             IR_Write,
  output logic             PC_Write,
  output logic [1:0]       PC_s,
  output logic [1:0]       w_r_s,
  output logic             imm_s,
  output logic             rt_imm_s,
  output logic [1:0]       wr_data_s,
  output logic [2:0]       ALU_OP,
  output logic             Write_Reg,
  output logic             Mem_Write,
  output logic             instr_done,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  instr_class_t cls;
  logic [2:0]   dec_alu;
  logic [1:0]   dec_wrs, dec_wds;
  logic         dec_imm, dec_rti;

  mc_instr_decoder u_dec (
    .OP        (OP),
    .func      (func),
    .cls       (cls),
    .alu_op    (dec_alu),
    .w_r_s     (dec_wrs),
    .imm_s     (dec_imm),
    .rt_imm_s  (dec_rti),
    .wr_data_s (dec_wds)
  );

  logic [2:0] state_q, state_d;
  logic       ir_w, pc_w, imm, rti, wreg, mw, done, ill;
  logic [1:0] pcs, wrs, wds;
  logic [2:0] alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       instr_cnt <= '0;
    else if (done) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    ir_w = 1'b0; pc_w = 1'b0; pcs = PC_S_PC4; wrs = WR_RD; imm = 1'b0; rti = 1'b0;
    wds = WD_ALU; alu = ALU_AND; wreg = 1'b0; mw = 1'b0; done = 1'b0; ill = 1'b0;
    // static selects only drive the datapath once the instruction is past ID
    if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
      alu = dec_alu; wrs = dec_wrs; imm = dec_imm; rti = dec_rti; wds = dec_wds;
    end
    case (state_q)
      S_IF: if (mem_ready) begin
        ir_w = 1'b1; pc_w = 1'b1; pcs = PC_S_PC4; state_d = S_ID;
      end
      S_ID: begin
        state_d = S_IF;
        case (cls)
          C_J:       begin pc_w = 1'b1; pcs = PC_S_JUMP; done = 1'b1; end
          C_JAL:     begin
            pc_w = 1'b1; pcs = PC_S_JUMP; done = 1'b1;
            wreg = 1'b1; wrs = WR_RA; wds = WD_PC4;
          end
          C_JR:      begin pc_w = 1'b1; pcs = PC_S_RS; done = 1'b1; end
          C_ILLEGAL: begin ill = 1'b1; done = 1'b1; end
          default:   state_d = S_EX;
        endcase
      end
      S_EX: begin
        case (cls)
          C_RALU, C_IALU: state_d = S_WB;
          C_LW, C_SW:     state_d = S_MEM;
          C_BR: begin
            pc_w = (OP == OP_BNE) ? ~ZF : ZF;
            pcs = PC_S_BRANCH; done = 1'b1; state_d = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        mw = (cls == C_SW);
        if (cls != C_SW && cls != C_LW) state_d = S_IF;
        else if (mem_ready) begin
          if (cls == C_SW) begin done = 1'b1; state_d = S_IF; end
          else state_d = S_WB;
        end
      end
      S_WB: begin
        wreg = 1'b1; done = 1'b1; state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // reset forces every control output low combinationally so no write escapes
  assign IR_Write   = ir_w & ~rst;
  assign PC_Write   = pc_w & ~rst;
  assign PC_s       = rst ? 2'b00 : pcs;
  assign w_r_s      = rst ? 2'b00 : wrs;
  assign imm_s      = imm & ~rst;
  assign rt_imm_s   = rti & ~rst;
  assign wr_data_s  = rst ? 2'b00 : wds;
  assign ALU_OP     = rst ? 3'b000 : alu;
  assign Write_Reg  = wreg & ~rst;
  assign Mem_Write  = mw & ~rst;
  assign instr_done = done & ~rst;
  assign illegal    = ill & ~rst;
  assign state      = rst ? S_IF : state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: per-cycle check of every control
// output against hand-derived vectors, plus counter and reset behaviour.
module tb_multi_cycle_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    OP, func;
  logic          ZF, mem_ready;
  logic          IR_Write, PC_Write, imm_s, rt_imm_s, Write_Reg, Mem_Write, instr_done, illegal;
  logic [1:0]    PC_s, w_r_s, wr_data_s;
  logic [2:0]    ALU_OP, state;
  logic [CW-1:0] instr_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_cycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .OP(OP), .func(func), .ZF(ZF), .mem_ready(mem_ready),
    .IR_Write(IR_Write), .PC_Write(PC_Write), .PC_s(PC_s), .w_r_s(w_r_s),
    .imm_s(imm_s), .rt_imm_s(rt_imm_s), .wr_data_s(wr_data_s), .ALU_OP(ALU_OP),
    .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .instr_done(instr_done),
    .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

  logic [19:0] obs;
  assign obs = {IR_Write, PC_Write, PC_s, w_r_s, imm_s, rt_imm_s, wr_data_s, ALU_OP,
                Write_Reg, Mem_Write, instr_done, illegal, state};

  function automatic logic [19:0] ev(input logic ir, pw, input logic [1:0] pcs, wrs,
                                     input logic imm, rti, input logic [1:0] wds,
                                     input logic [2:0] alu, input logic wreg, mw, done, ill,
                                     input logic [2:0] st);
    return {ir, pw, pcs, wrs, imm, rti, wds, alu, wreg, mw, done, ill, st};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // inputs are set at a negedge; outputs are sampled 1 time unit later
  task automatic step(input string tag, input logic [19:0] e);
    #1 chk(tag, {12'h0, obs}, {12'h0, e});
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    OP = op; func = fn; ZF = z;
  endtask

  logic [19:0] E_IF, E_ID, E_IDLE;

  initial begin
    E_IF   = ev(1, 1, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 3'd0);
    E_ID   = ev(0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 3'd1);
    E_IDLE = 20'h0;

    rst = 1'b1; mem_ready = 1'b1; set_instr(6'b000000, 6'b100000, 1'b0);
    @(negedge clk);
    #1 chk("rst_outputs", {12'h0, obs}, 32'h0);
    chk("rst_cnt", 32'(instr_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    mem_ready = 1'b0;
    step("if_wait0", E_IDLE);
    step("if_wait1", E_IDLE);
    mem_ready = 1'b1;

    // add
    step("add_if", E_IF);
    step("add_id", E_ID);
    step("add_ex", ev(0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b100, 0, 0, 0, 0, 3'd2));
    step("add_wb", ev(0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b100, 1, 0, 1, 0, 3'd4));
    chk("add_cnt", 32'(instr_cnt), 1);

    // lw with three wait cycles in MEM
    set_instr(6'b100011, 6'b000000, 1'b0);
    step("lw_if", E_IF);
    step("lw_id", E_ID);
    step("lw_ex", ev(0, 0, 2'b00, 2'b01, 1, 1, 2'b01, 3'b100, 0, 0, 0, 0, 3'd2));
    mem_ready = 1'b0;
    step("lw_mem_w0", ev(0, 0, 2'b00, 2'b01, 1, 1, 2'b01, 3'b100, 0, 0, 0, 0, 3'd3));
    step("lw_mem_w1", ev(0, 0, 2'b00, 2'b01, 1, 1, 2'b01, 3'b100, 0, 0, 0, 0, 3'd3));
    step("lw_mem_w2", ev(0, 0, 2'b00, 2'b01, 1, 1, 2'b01, 3'b100, 0, 0, 0, 0, 3'd3));
    mem_ready = 1'b1;
    step("lw_mem_rdy", ev(0, 0, 2'b00, 2'b01, 1, 1, 2'b01, 3'b100, 0, 0, 0, 0, 3'd3));
    step("lw_wb", ev(0, 0, 2'b00, 2'b01, 1, 1, 2'b01, 3'b100, 1, 0, 1, 0, 3'd4));
    chk("lw_cnt", 32'(instr_cnt), 2);

    // sw
    set_instr(6'b101011, 6'b000000, 1'b0);
    step("sw_if", E_IF);
    step("sw_id", E_ID);
    step("sw_ex", ev(0, 0, 2'b00, 2'b00, 1, 1, 2'b00, 3'b100, 0, 0, 0, 0, 3'd2));
    step("sw_mem", ev(0, 0, 2'b00, 2'b00, 1, 1, 2'b00, 3'b100, 0, 1, 1, 0, 3'd3));
    chk("sw_cnt", 32'(instr_cnt), 3);

    // branches
    set_instr(6'b000100, 6'b000000, 1'b1);
    step("beq1_if", E_IF); step("beq1_id", E_ID);
    step("beq1_ex", ev(0, 1, 2'b10, 2'b00, 1, 0, 2'b00, 3'b101, 0, 0, 1, 0, 3'd2));
    set_instr(6'b000100, 6'b000000, 1'b0);
    step("beq0_if", E_IF); step("beq0_id", E_ID);
    step("beq0_ex", ev(0, 0, 2'b10, 2'b00, 1, 0, 2'b00, 3'b101, 0, 0, 1, 0, 3'd2));
    set_instr(6'b000101, 6'b000000, 1'b1);
    step("bne1_if", E_IF); step("bne1_id", E_ID);
    step("bne1_ex", ev(0, 0, 2'b10, 2'b00, 1, 0, 2'b00, 3'b101, 0, 0, 1, 0, 3'd2));
    set_instr(6'b000101, 6'b000000, 1'b0);
    step("bne0_if", E_IF); step("bne0_id", E_ID);
    step("bne0_ex", ev(0, 1, 2'b10, 2'b00, 1, 0, 2'b00, 3'b101, 0, 0, 1, 0, 3'd2));
    chk("br_cnt", 32'(instr_cnt), 7);

    // jumps and an illegal opcode
    set_instr(6'b000011, 6'b000000, 1'b0);
    step("jal_if", E_IF);
    step("jal_id", ev(0, 1, 2'b11, 2'b10, 0, 0, 2'b10, 3'b000, 1, 0, 1, 0, 3'd1));
    set_instr(6'b111111, 6'b000000, 1'b0);
    step("ill_if", E_IF);
    step("ill_id", ev(0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0, 1, 1, 3'd1));
    set_instr(6'b000000, 6'b111111, 1'b0);
    step("illf_if", E_IF);
    step("illf_id", ev(0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0, 1, 1, 3'd1));
    set_instr(6'b000010, 6'b000000, 1'b0);
    step("j_if", E_IF);
    step("j_id", ev(0, 1, 2'b11, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0, 1, 0, 3'd1));
    set_instr(6'b000000, 6'b001000, 1'b0);
    step("jr_if", E_IF);
    step("jr_id", ev(0, 1, 2'b01, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0, 1, 0, 3'd1));
    chk("jmp_cnt", 32'(instr_cnt), 12);

    // xori
    set_instr(6'b001110, 6'b000000, 1'b0);
    step("xori_if", E_IF); step("xori_id", E_ID);
    step("xori_ex", ev(0, 0, 2'b00, 2'b01, 0, 1, 2'b00, 3'b010, 0, 0, 0, 0, 3'd2));
    step("xori_wb", ev(0, 0, 2'b00, 2'b01, 0, 1, 2'b00, 3'b010, 1, 0, 1, 0, 3'd4));
    chk("xori_cnt", 32'(instr_cnt), 13);

    // reset asserted while sw waits in MEM
    set_instr(6'b101011, 6'b000000, 1'b0);
    step("swr_if", E_IF); step("swr_id", E_ID);
    step("swr_ex", ev(0, 0, 2'b00, 2'b00, 1, 1, 2'b00, 3'b100, 0, 0, 0, 0, 3'd2));
    mem_ready = 1'b0;
    #1 chk("swr_mem", {12'h0, obs}, {12'h0, ev(0, 0, 2'b00, 2'b00, 1, 1, 2'b00, 3'b100, 0, 1, 0, 0, 3'd3)});
    rst = 1'b1;
    #1 chk("swr_rst_outputs", {12'h0, obs}, 32'h0);
    chk("swr_rst_cnt", 32'(instr_cnt), 0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;

    // counter wrap: 15 jumps to all-ones, then two more
    set_instr(6'b000010, 6'b000000, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step("wrap_if", E_IF);
      step("wrap_id", ev(0, 1, 2'b11, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0, 1, 0, 3'd1));
    end
    chk("cnt_ones", 32'(instr_cnt), 15);
    step("wrap_if", E_IF);
    step("wrap_id", ev(0, 1, 2'b11, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0, 1, 0, 3'd1));
    chk("cnt_wrap0", 32'(instr_cnt), 0);
    step("wrap_if", E_IF);
    step("wrap_id", ev(0, 1, 2'b11, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0, 1, 0, 3'd1));
    chk("cnt_wrap1", 32'(instr_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
